// File: rtl/barrel_rot_arbiter_if.sv
// rtl/barrel_rot_arbiter_if.sv - requester, result and counter signals of the shared rotate arbiter
interface barrel_rot_arbiter_if #(
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic             req0_ready;
    logic [7:0]       req0_data;
    logic [2:0]       req0_amt;
    logic             req0_dir;
    logic             req1_valid;
    logic             req1_ready;
    logic [7:0]       req1_data;
    logic [2:0]       req1_amt;
    logic             req1_dir;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_id;
    logic [CNT_W-1:0] op_count;

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_dir,
        input  req1_valid, req1_data, req1_amt, req1_dir,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_id, op_count
    );

    modport master (
        output req0_valid, req0_data, req0_amt, req0_dir,
        output req1_valid, req1_data, req1_amt, req1_dir,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_id, op_count
    );
endinterface

// File: rtl/barrel_rot_arbiter.sv
// rtl/barrel_rot_arbiter.sv - round-robin sharing of one 8-bit rotate-right shifter between two requesters
module barrel_shifter_8bit (
    input  logic [7:0] data_i,
    input  logic [2:0] sel_i,
    output logic [7:0] data_o
);
    logic [15:0] dbl;

    assign dbl    = {data_i, data_i} >> sel_i;
    assign data_o = dbl[7:0];
endmodule

module barrel_rot_arbiter #(
    parameter logic RR_INIT = 1'b0,
    parameter int   CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    barrel_rot_arbiter_if.slave  bus
);
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_id_q, out_id_d;
    logic             ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       slot_free;
    logic       any_valid;
    logic       grant;
    logic       accept;
    logic [7:0] g_data;
    logic [2:0] g_amt;
    logic       g_dir;
    logic [2:0] sel;
    logic [7:0] shift_out;

    assign slot_free = !out_valid_q || bus.out_ready;
    assign any_valid = bus.req0_valid || bus.req1_valid;
    // With a single requester valid, grant follows it; the pointer only breaks ties.
    assign grant     = (bus.req0_valid && bus.req1_valid) ? ptr_q : bus.req1_valid;
    assign accept    = !rst && slot_free && any_valid;

    assign bus.req0_ready = accept && !grant;
    assign bus.req1_ready = accept && grant;

    assign g_data = grant ? bus.req1_data : bus.req0_data;
    assign g_amt  = grant ? bus.req1_amt  : bus.req0_amt;
    assign g_dir  = grant ? bus.req1_dir  : bus.req0_dir;
    // Left by n equals right by (8-n) mod 8.
    assign sel    = g_dir ? (3'd0 - g_amt) : g_amt;

    barrel_shifter_8bit u_shifter (
        .data_i (g_data),
        .sel_i  (sel),
        .data_o (shift_out)
    );

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = shift_out;
            out_id_d    = grant;
            ptr_d       = !grant;
            cnt_d       = cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_id_q    <= 1'b0;
            ptr_q       <= RR_INIT;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_id    = out_id_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_barrel_rot_arbiter.sv
// tb/tb_barrel_rot_arbiter.sv - directed and randomized checks of barrel_rot_arbiter against a rotate/round-robin model
module tb_barrel_rot_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    barrel_rot_arbiter_if #(.CNT_W(8)) bus ();

    barrel_rot_arbiter #(.RR_INIT(1'b0), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    bit m_valid;
    int m_data;
    int m_id;
    int m_count;
    int m_prio;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int rot(input int x, input int amt, input int dir);
        int r;
        if (dir == 0) r = (x >> amt) | (x << (8 - amt));
        else          r = (x << amt) | (x >> (8 - amt));
        return r & 255;
    endfunction

    function automatic int model_grant();
        if (bus.req0_valid && bus.req1_valid) return m_prio;
        if (bus.req0_valid) return 0;
        if (bus.req1_valid) return 1;
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 0;
        m_id    = 0;
        m_count = 0;
        m_prio  = 0;
    endtask

    task automatic drive(input bit v0, input int d0, input int a0, input bit r0,
                         input bit v1, input int d1, input int a1, input bit r1,
                         input bit ordy);
        bus.req0_valid = v0;
        bus.req0_data  = 8'(d0);
        bus.req0_amt   = 3'(a0);
        bus.req0_dir   = r0;
        bus.req1_valid = v1;
        bus.req1_data  = 8'(d1);
        bus.req1_amt   = 3'(a1);
        bus.req1_dir   = r1;
        bus.out_ready  = ordy;
    endtask

    // Called at posedge+1 with inputs already driven; returns at the next posedge+1.
    task automatic do_cycle(input string tag);
        int g;
        bit n_valid;
        int n_data, n_id, n_count, n_prio;
        #2;
        g = (!m_valid || bus.out_ready) ? model_grant() : -1;
        chk({tag, "_rdy0"}, bus.req0_ready, (g == 0));
        chk({tag, "_rdy1"}, bus.req1_ready, (g == 1));
        n_valid = m_valid; n_data = m_data; n_id = m_id;
        n_count = m_count; n_prio = m_prio;
        if (g == 0) begin
            n_data = rot(bus.req0_data, bus.req0_amt, bus.req0_dir);
        end else if (g == 1) begin
            n_data = rot(bus.req1_data, bus.req1_amt, bus.req1_dir);
        end
        if (g >= 0) begin
            n_valid = 1'b1;
            n_id    = g;
            n_prio  = 1 - g;
            n_count = (m_count + 1) % 256;
        end else if (m_valid && bus.out_ready) begin
            n_valid = 1'b0;
        end
        @(posedge clk);
        m_valid = n_valid; m_data = n_data; m_id = n_id;
        m_count = n_count; m_prio = n_prio;
        #1;
        chk({tag, "_valid"}, bus.out_valid, m_valid);
        chk({tag, "_data"},  bus.out_data,  m_data);
        chk({tag, "_id"},    bus.out_id,    m_id);
        chk({tag, "_cnt"},   bus.op_count,  m_count);
    endtask

    initial begin
        rst = 1'b1;
        drive(1, 'h11, 1, 0, 1, 'h22, 2, 1, 1);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data",  bus.out_data,  0);
        chk("rst_id",    bus.out_id,    0);
        chk("rst_cnt",   bus.op_count,  0);
        chk("rst_rdy0",  bus.req0_ready, 0);
        chk("rst_rdy1",  bus.req1_ready, 0);
        rst = 1'b0;

        drive(1, 'h81, 1, 0, 0, 0, 0, 0, 1);
        do_cycle("rr");
        chk("rr_data_c", bus.out_data, 8'hC0);
        chk("rr_id_c",   bus.out_id,   0);
        chk("rr_cnt_c",  bus.op_count, 1);

        drive(0, 0, 0, 0, 1, 'h81, 3, 1, 1);
        do_cycle("rl");
        chk("rl_data_c", bus.out_data, 8'h0C);
        chk("rl_id_c",   bus.out_id,   1);
        drive(0, 0, 0, 0, 1, 'hA5, 0, 1, 1);
        do_cycle("rl0");
        chk("rl0_data_c", bus.out_data, 8'hA5);

        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom, $urandom_range(0, 7), $urandom_range(0, 1),
                  1, $urandom, $urandom_range(0, 7), $urandom_range(0, 1), 1);
            do_cycle("cont");
            chk("cont_id_c",    bus.out_id,    i % 2);
            chk("cont_valid_c", bus.out_valid, 1);
        end

        drive(1, 'h3C, 0, 0, 0, 0, 0, 0, 1);
        do_cycle("bp_load");
        chk("bp_load_c", bus.out_data, 8'h3C);
        for (int i = 0; i < 4; i++) begin
            drive(1, $urandom, $urandom_range(0, 7), 0, 1, $urandom, $urandom_range(0, 7), 1, 0);
            do_cycle("bp");
            chk("bp_data_c",  bus.out_data,  8'h3C);
            chk("bp_valid_c", bus.out_valid, 1);
        end
        drive(0, 0, 0, 0, 1, 'h0F, 4, 1, 1);
        do_cycle("bp_repl");
        chk("bp_repl_data_c",  bus.out_data,  8'hF0);
        chk("bp_repl_valid_c", bus.out_valid, 1);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), $urandom, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 3) != 0);
            do_cycle("rand");
        end

        drive(1, 'h55, 2, 0, 0, 0, 0, 0, 1);
        do_cycle("pre_rst");
        chk("pre_rst_valid_c", bus.out_valid, 1);
        drive(1, 'h12, 1, 0, 1, 'h34, 1, 0, 0);
        rst = 1'b1;
        #1;
        chk("midrst_valid", bus.out_valid,  0);
        chk("midrst_cnt",   bus.op_count,   0);
        chk("midrst_rdy0",  bus.req0_ready, 0);
        chk("midrst_rdy1",  bus.req1_ready, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1, 'h12, 1, 0, 1, 'h34, 1, 0, 1);
        do_cycle("post_rst");
        chk("post_rst_id_c", bus.out_id, 0);

        for (int i = 0; i < 255; i++) begin
            drive(1, $urandom, $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 7), $urandom_range(0, 1), 1);
            do_cycle("wrap");
        end
        chk("wrap_cnt_c", bus.op_count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/barrel_rot_arbiter.md
Name: barrel_rot_arbiter

Overview:
- Shares one `barrel_shifter_8bit` instance (8-bit rotate-right by `sel`) between two requesters.
- Round-robin arbitration, per-requester valid/ready handshake.
- Left rotates are converted to the equivalent right rotate.
- Results go to a one-entry registered output stage with valid/ready backpressure and requester ID. Sits between command sources (e.g. two datapath sequencers) and a downstream consumer.

Parameters:
- RR_INIT, 0, requester holding priority after reset (0 or 1).
- CNT_W, 8, width of accepted-operation counter.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset; asynchronous, active-high
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle (when valid)
- req0_data  input  8  requester 0 operand
- req0_amt  input  3  requester 0 rotate amount
- req0_dir  input  1  requester 0 direction: 0 = rotate right, 1 = rotate left
- req1_valid, req1_ready, req1_data, req1_amt, req1_dir  same as requester 0, for requester 1
- out_valid  output  1  result register holds a valid result
- out_ready  input  1  consumer accepts result
- out_data  output  8  rotated result
- out_id  output  1  requester that issued the result
- op_count  output  CNT_W  number of accepted operations, wraps

Behaviour:
- Reset (async assert, sync use on next edge):
  - out_valid=0, out_data=0x00, out_id=0, op_count=0.
  - Priority pointer = RR_INIT.
  - req*_ready are forced 0 while rst is high.
- State is the output slot: EMPTY (out_valid=0) or FULL (out_valid=1).
- slot_free = !out_valid | out_ready, combinational.
- Grant (combinational):
  - Both valid: grant = pointer.
  - One valid: grant = that requester.
  - None valid: no grant.
- reqN_ready = slot_free & reqN_valid & (grant==N). At most one ready high per cycle; never high for a non-granted requester.
- Accept = reqN_valid & reqN_ready.
- Shifter drive:
  - sel = amt when dir=0.
  - sel = (8 - amt) mod 8 (3-bit two's complement negate) when dir=1.
  - Operand/sel come from the granted requester.
- On accept, at the next edge:
  - out_data <= shifter output; out_id <= N; out_valid <= 1.
  - pointer <= ~N, so the requester just served loses priority.
  - op_count <= op_count + 1, modulo 2^CNT_W.
- Latency: accept in cycle T gives out_valid=1 with the result in cycle T+1.
- Throughput: one operation per cycle when out_ready is held high.
- Drain without accept: out_valid & out_ready & no accept gives out_valid <= 0. out_data/out_id hold their last values.
- Simultaneous drain and accept: the new result replaces the old one in the same edge and out_valid stays 1. No bubble, no loss.
- Backpressure: out_valid=1 & out_ready=0 gives all req*_ready=0. out_data/out_id/out_valid stay stable until drained.
- Pointer changes only on accept. An idle requester does not consume its turn.
- Inputs need only be stable in the accepting cycle. The block does not register the requester's data before accept.
- Reset mid-operation: a pending result is discarded (out_valid=0 immediately on rst assert) and op_count is cleared.
- amt=0 with either dir gives sel=0, i.e. pass-through. dir=1 with amt=4 gives sel=4.

Test Plan:
- Right rotate: req0 data=0x81, amt=1, dir=0, out_ready=1 -> next cycle out_valid=1, out_data=0xC0, out_id=0, op_count=1.
- Left rotate: req1 data=0x81, amt=3, dir=1 -> out_data=0x0C, out_id=1. Also amt=0, dir=1, data=0xA5 -> out_data=0xA5.
- Contention: both valid every cycle with RR_INIT=0, out_ready=1 -> out_id sequence 0,1,0,1 on consecutive cycles. Exactly one ready per cycle; throughput one per cycle.
- Backpressure: out_ready=0 with result 0x3C pending for 4 cycles -> both readies 0, out_data=0x3C stable. out_ready=1 with a new request the same cycle -> replacement next cycle, out_valid stays 1.
- Reset mid-flight: assert rst while out_valid=1 -> out_valid=0 and op_count=0 immediately (no clock edge needed). After release, the first grant with both valid goes to RR_INIT.
- Counter wrap: 256 accepted operations with CNT_W=8 -> op_count returns to 0x00.
